// File: rtl/cnic_tx_packetizer.sv
// -----------------------------------------------------------------------------
// cnic_tx_packetizer
//
// Transmit-side packetizer that sits directly in front of the flit packer.
// It accepts one packet request (destination and length), then takes one
// payload word per flit from the local core. For each word it presents a
// registered flit bundle to the packer. The bundle carries the payload, the
// flit type, a running sequence number, the destination and the source.
// The packer reflects its link status back. While a flit is held
// unconsumed, the bundle stays frozen and no new word is taken.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   src_id            this node's coordinates (captured per packet)
//   req_valid/ready   packet request handshake
//   req_dest          destination coordinates of the requested packet
//   req_len_m1        flits in the packet minus one (1..16 flits)
//   wr_valid/ready    payload word handshake
//   wr_data           payload word
//   payload           flit payload to packer
//   flit_type         00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE
//   pack_enable       flit bundle valid
//   dest, src         destination / source of the current packet
//   SN_out            per-flit sequence number (wraps 31 -> 0 across packets)
//   link_status       1 = the flit presented this cycle is consumed
//   busy              a packet is in progress
//   pkt_done          one-cycle pulse after the last flit is consumed
// -----------------------------------------------------------------------------
module cnic_tx_packetizer #(
    parameter int PAYLOAD_WIDTH   = 32,
    parameter int FLIT_TYPE_WIDTH = 2,
    parameter int XY_WIDTH        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*XY_WIDTH-1:0]      src_id,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2*XY_WIDTH-1:0]      req_dest,
    input  logic [3:0]                 req_len_m1,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [PAYLOAD_WIDTH-1:0]   wr_data,
    output logic [PAYLOAD_WIDTH-1:0]   payload,
    output logic [FLIT_TYPE_WIDTH-1:0] flit_type,
    output logic                       pack_enable,
    output logic [2*XY_WIDTH-1:0]      dest,
    output logic [2*XY_WIDTH-1:0]      src,
    output logic [4:0]                 SN_out,
    input  logic                       link_status,
    output logic                       busy,
    output logic                       pkt_done
);

    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_BODY   = FLIT_TYPE_WIDTH'(0);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_HEAD   = FLIT_TYPE_WIDTH'(1);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_TAIL   = FLIT_TYPE_WIDTH'(2);
    localparam logic [FLIT_TYPE_WIDTH-1:0] FT_SINGLE = FLIT_TYPE_WIDTH'(3);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN
    } state_t;

    state_t                      state;
    logic [3:0]                  len_m1;
    logic [3:0]                  idx;
    logic [2*XY_WIDTH-1:0]       cap_dest;
    logic [2*XY_WIDTH-1:0]       cap_src;
    logic [4:0]                  sn_cnt;

    logic                        free;
    logic                        req_fire;
    logic                        wr_fire;
    logic                        consume;
    logic [FLIT_TYPE_WIDTH-1:0]  next_type;

    // The output register can take a new flit when it is empty or when its
    // current flit leaves this cycle. Handshakes are masked during reset so
    // that nothing fires while the block is being cleared.
    assign free      = !pack_enable || link_status;
    assign req_ready = (state == IDLE) && !rst;
    assign wr_ready  = (state == SEND) && free && !rst;
    assign req_fire  = req_valid && req_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign consume   = pack_enable && link_status;
    assign busy      = (state != IDLE);

    // Flit type of the word about to be loaded, from its position in the packet.
    always_comb begin
        next_type = FT_BODY;
        if (len_m1 == 4'd0) begin
            next_type = FT_SINGLE;
        end else if (idx == 4'd0) begin
            next_type = FT_HEAD;
        end else if (idx == len_m1) begin
            next_type = FT_TAIL;
        end
    end

    // Packet FSM and registered flit bundle. The bundle only changes on a
    // word fire (new flit) or on consumption without a refill (valid drops).
    // Together with wr_ready being low during a stall, this keeps every
    // field frozen while the packer is backpressuring.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_m1      <= '0;
            idx         <= '0;
            cap_dest    <= '0;
            cap_src     <= '0;
            sn_cnt      <= '0;
            payload     <= '0;
            flit_type   <= FT_BODY;
            pack_enable <= 1'b0;
            dest        <= '0;
            src         <= '0;
            SN_out      <= '0;
            pkt_done    <= 1'b0;
        end else begin
            pkt_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_fire) begin
                        cap_dest <= req_dest;
                        cap_src  <= src_id;
                        len_m1   <= req_len_m1;
                        idx      <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (wr_fire && (idx == len_m1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (consume) begin
                        state    <= IDLE;
                        pkt_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_fire) begin
                payload     <= wr_data;
                flit_type   <= next_type;
                pack_enable <= 1'b1;
                dest        <= cap_dest;
                src         <= cap_src;
                SN_out      <= sn_cnt;
                sn_cnt      <= sn_cnt + 5'd1;
                idx         <= idx + 4'd1;
            end else if (consume) begin
                pack_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnic_tx_packetizer.sv
// -----------------------------------------------------------------------------
// tb_cnic_tx_packetizer
//
// Self-checking bench for cnic_tx_packetizer. Each scenario task drives its
// own stimulus and compares the DUT outputs against expectations derived
// from the packet rules:
//   - flit type from position in packet
//   - a sequence counter kept by the bench
//   - a queue of flits expected on the packer interface
// Outputs are sampled on the falling clock edge. Inputs are driven on the
// falling clock edge as well.
// -----------------------------------------------------------------------------
module tb_cnic_tx_packetizer;

    logic        clk;
    logic        rst;
    logic [3:0]  src_id;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dest;
    logic [3:0]  req_len_m1;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [31:0] payload;
    logic [1:0]  flit_type;
    logic        pack_enable;
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [4:0]  SN_out;
    logic        link_status;
    logic        busy;
    logic        pkt_done;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  sn_model = '0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  ftype;
        logic [4:0]  sn;
        logic [3:0]  dst;
        logic [3:0]  sr;
        logic        last;
    } flit_t;

    cnic_tx_packetizer #(
        .PAYLOAD_WIDTH   (32),
        .FLIT_TYPE_WIDTH (2),
        .XY_WIDTH        (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_id      (src_id),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dest    (req_dest),
        .req_len_m1  (req_len_m1),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .payload     (payload),
        .flit_type   (flit_type),
        .pack_enable (pack_enable),
        .dest        (dest),
        .src         (src),
        .SN_out      (SN_out),
        .link_status (link_status),
        .busy        (busy),
        .pkt_done    (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flit type from position i in a packet of len_m1+1 flits.
    function automatic logic [1:0] exp_type(input int i, input int len);
        if (len == 0) return 2'b11;
        if (i == 0) return 2'b01;
        if (i == len) return 2'b10;
        return 2'b00;
    endfunction

    // Holds reset for the given number of cycles and leaves the inputs quiet.
    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        wr_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        sn_model = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({payload, flit_type, pack_enable, dest, src, SN_out, busy, pkt_done} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_regs: got pe=%b pl=%h ty=%b d=%h s=%h sn=%0d busy=%b done=%b required all 0",
                         pack_enable, payload, flit_type, dest, src, SN_out, busy, pkt_done);
            end
            req_valid   = 1'($urandom_range(0, 1));
            req_dest    = 4'($urandom);
            req_len_m1  = 4'($urandom);
            wr_valid    = 1'($urandom_range(0, 1));
            wr_data     = $urandom;
            link_status = 1'($urandom_range(0, 1));
            src_id      = 4'($urandom);
            #1;
            checks++;
            if (req_ready !== 1'b0 || wr_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_ready: got req_ready=%b wr_ready=%b required 0 0", req_ready, wr_ready);
            end
        end
        @(negedge clk);
        checks++;
        if ({payload, flit_type, pack_enable, dest, src, SN_out, busy, pkt_done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got pe=%b sn=%0d busy=%b done=%b required all 0",
                     pack_enable, SN_out, busy, pkt_done);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        wr_valid = 1'b0;
        link_status = 1'b1;
        sn_model = '0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset: got req_ready=%b busy=%b wr_ready=%b required 1 0 0",
                     req_ready, busy, wr_ready);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        src_id = 4'hA;
        req_dest = 4'h5;
        req_len_m1 = 4'd0;
        req_valid = 1'b1;
        link_status = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_req_ready: got %b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_dest = 4'h3;
        src_id = 4'h6;
        checks++;
        if (busy !== 1'b1 || pack_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_busy: got busy=%b pe=%b required 1 0", busy, pack_enable);
        end
        wr_valid = 1'b1;
        wr_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_wr_ready: got %b required 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wr_data = $urandom;
        checks++;
        if ({pack_enable, flit_type, SN_out, dest, src, payload} !== {1'b1, 2'b11, sn_model, 4'h5, 4'hA, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL single_flit: got pe=%b ty=%b sn=%0d d=%h s=%h pl=%h required 1 11 %0d 5 a deadbeef",
                     pack_enable, flit_type, SN_out, dest, src, payload, sn_model);
        end
        sn_model++;
        src_id = 4'hA;
        @(negedge clk);
        checks++;
        if (pkt_done !== 1'b1 || pack_enable !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_done: got done=%b pe=%b busy=%b req_ready=%b required 1 0 0 1",
                     pkt_done, pack_enable, busy, req_ready);
        end
        @(negedge clk);
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done_pulse: got %b required 0", pkt_done);
        end
    endtask

    task automatic test_four_flit();
        logic [31:0] words [4];
        logic [3:0]  d;
        d = 4'($urandom);
        @(negedge clk);
        req_valid = 1'b1;
        req_dest = d;
        req_len_m1 = 4'd3;
        link_status = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL four_req_ready: got %b required 1", req_ready);
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (i > 0) begin
                checks++;
                if ({pack_enable, flit_type, SN_out, dest, src, payload, pkt_done} !==
                    {1'b1, exp_type(i - 1, 3), sn_model, d, src_id, words[i - 1], 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL four_flit%0d: got pe=%b ty=%b sn=%0d d=%h pl=%h done=%b required 1 %b %0d %h %h 0",
                             i - 1, pack_enable, flit_type, SN_out, dest, payload, pkt_done,
                             exp_type(i - 1, 3), sn_model, d, words[i - 1]);
                end
                sn_model++;
            end
            if (i < 4) begin
                words[i] = $urandom;
                wr_valid = 1'b1;
                wr_data = words[i];
                #1;
                checks++;
                if (wr_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL four_wr_ready%0d: got %b required 1", i, wr_ready);
                end
            end else begin
                wr_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (pkt_done !== 1'b1 || pack_enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL four_done: got done=%b pe=%b busy=%b required 1 0 0", pkt_done, pack_enable, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [4];
        logic [3:0]  d;
        logic [4:0]  sn_base;
        int          ws;
        int          k;
        logic        stall;
        d = 4'($urandom);
        sn_base = sn_model;
        ws = 0;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        @(negedge clk);
        req_valid = 1'b1;
        req_dest = d;
        req_len_m1 = 4'd3;
        link_status = 1'b1;
        // Cycle c presents flit k: flit 1 is held through the 3 stall cycles
        // (c = 2..4) and again on c = 5 when the link recovers.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            k = (c <= 1) ? 0 : ((c <= 5) ? 1 : c - 4);
            stall = (c >= 2 && c <= 4);
            if (c > 0) begin
                checks++;
                if ({pack_enable, flit_type, SN_out, dest, payload} !==
                    {1'b1, exp_type(k, 3), 5'(sn_base + 5'(k)), d, words[k]}) begin
                    errors++;
                    $display("[TB] FAIL bp_flit_c%0d: got pe=%b ty=%b sn=%0d d=%h pl=%h required 1 %b %0d %h %h",
                             c, pack_enable, flit_type, SN_out, dest, payload,
                             exp_type(k, 3), 5'(sn_base + 5'(k)), d, words[k]);
                end
            end
            link_status = !stall;
            if (ws < 4) begin
                wr_valid = 1'b1;
                wr_data = words[ws];
                #1;
                checks++;
                if (wr_ready !== !stall) begin
                    errors++;
                    $display("[TB] FAIL bp_wr_ready_c%0d: got %b required %b", c, wr_ready, !stall);
                end
                if (wr_ready) ws++;
            end else begin
                wr_valid = 1'b0;
            end
        end
        sn_model = sn_base + 5'd4;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if (pkt_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_done: got done=%b busy=%b required 1 0", pkt_done, busy);
        end
    endtask

    task automatic test_back_to_back(input int n_pkts);
        flit_t       exp_q[$];
        logic [31:0] words_q[$];
        flit_t       f;
        int          pkts_req;
        int          dones;
        int          cyc;
        logic        active;
        logic        done_exp;
        logic        idle_now;
        logic        prev_stall;
        logic [46:0] snap;
        logic [3:0]  cur_dest;
        logic [3:0]  cur_len;
        logic [3:0]  widx;
        pkts_req = 0;
        dones = 0;
        cyc = 0;
        active = 1'b0;
        done_exp = 1'b0;
        prev_stall = 1'b0;
        snap = '0;
        cur_dest = '0;
        cur_len = '0;
        widx = '0;
        src_id = 4'($urandom);
        while ((pkts_req < n_pkts || active || exp_q.size() > 0 || done_exp) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            idle_now = !active && (exp_q.size() == 0);
            checks++;
            if (busy !== !idle_now || req_ready !== idle_now) begin
                errors++;
                $display("[TB] FAIL b2b_state cyc %0d: got busy=%b req_ready=%b required %b %b",
                         cyc, busy, req_ready, !idle_now, idle_now);
            end
            checks++;
            if (pkt_done !== done_exp) begin
                errors++;
                $display("[TB] FAIL b2b_pkt_done cyc %0d: got %b required %b", cyc, pkt_done, done_exp);
            end
            if (pkt_done === 1'b1) dones++;
            done_exp = 1'b0;
            if (prev_stall) begin
                checks++;
                if ({payload, flit_type, SN_out, dest, src} !== snap) begin
                    errors++;
                    $display("[TB] FAIL b2b_hold cyc %0d: got %h required %h", cyc,
                             {payload, flit_type, SN_out, dest, src}, snap);
                end
            end
            checks++;
            if (pack_enable !== (exp_q.size() > 0)) begin
                errors++;
                $display("[TB] FAIL b2b_pack_enable cyc %0d: got %b required %b", cyc, pack_enable, exp_q.size() > 0);
            end else if (exp_q.size() > 0) begin
                f = exp_q[0];
                checks++;
                if ({payload, flit_type, SN_out, dest, src} !== {f.data, f.ftype, f.sn, f.dst, f.sr}) begin
                    errors++;
                    $display("[TB] FAIL b2b_flit cyc %0d: got pl=%h ty=%b sn=%0d d=%h s=%h required %h %b %0d %h %h",
                             cyc, payload, flit_type, SN_out, dest, src, f.data, f.ftype, f.sn, f.dst, f.sr);
                end
            end
            link_status = ($urandom_range(0, 3) != 0);
            snap = {payload, flit_type, SN_out, dest, src};
            prev_stall = pack_enable && !link_status;
            req_valid = 1'b0;
            if (!active && pkts_req < n_pkts) begin
                req_valid = 1'($urandom_range(0, 1));
                req_dest = 4'($urandom);
                req_len_m1 = 4'($urandom);
            end
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data = active ? words_q[0] : $urandom;
            #1;
            checks++;
            if (wr_ready !== (active && (exp_q.size() == 0 || link_status))) begin
                errors++;
                $display("[TB] FAIL b2b_wr_ready cyc %0d: got %b required %b", cyc, wr_ready,
                         active && (exp_q.size() == 0 || link_status));
            end
            if (exp_q.size() > 0 && link_status) begin
                if (exp_q[0].last) done_exp = 1'b1;
                void'(exp_q.pop_front());
            end
            if (active && wr_valid && (exp_q.size() == 0 || link_status || pack_enable == 1'b0)) begin
                exp_q.push_back('{data: words_q.pop_front(), ftype: exp_type(int'(widx), int'(cur_len)),
                                  sn: sn_model, dst: cur_dest, sr: src_id, last: (widx == cur_len)});
                sn_model++;
                if (widx == cur_len) active = 1'b0;
                widx++;
            end
            if (req_valid && idle_now) begin
                active = 1'b1;
                cur_dest = req_dest;
                cur_len = req_len_m1;
                widx = '0;
                for (int w = 0; w <= int'(req_len_m1); w++) words_q.push_back($urandom);
                pkts_req++;
            end
        end
        req_valid = 1'b0;
        wr_valid = 1'b0;
        link_status = 1'b1;
        checks++;
        if (cyc >= 4000 || dones != n_pkts) begin
            errors++;
            $display("[TB] FAIL b2b_complete: got %0d packets done in %0d cycles required %0d", dones, cyc, n_pkts);
        end
    endtask

    task automatic test_sn_wrap();
        logic [31:0] w;
        apply_reset(2);
        link_status = 1'b1;
        for (int p = 0; p < 34; p++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_dest = 4'($urandom);
            req_len_m1 = 4'd0;
            @(negedge clk);
            req_valid = 1'b0;
            w = $urandom;
            wr_valid = 1'b1;
            wr_data = w;
            @(negedge clk);
            wr_valid = 1'b0;
            checks++;
            if ({pack_enable, flit_type, SN_out, payload} !== {1'b1, 2'b11, 5'(p % 32), w}) begin
                errors++;
                $display("[TB] FAIL wrap_pkt%0d: got pe=%b ty=%b sn=%0d pl=%h required 1 11 %0d %h",
                         p, pack_enable, flit_type, SN_out, payload, p % 32, w);
            end
            sn_model++;
            @(negedge clk);
            checks++;
            if (pkt_done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL wrap_done%0d: got %b required 1", p, pkt_done);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0;
        logic [31:0] w1;
        @(negedge clk);
        req_valid = 1'b1;
        req_dest = 4'($urandom);
        req_len_m1 = 4'd3;
        link_status = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            wr_valid = 1'b1;
            wr_data = $urandom;
        end
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_ready: got req_ready=%b wr_ready=%b required 0 0", req_ready, wr_ready);
        end
        @(negedge clk);
        checks++;
        if (pack_enable !== 1'b0 || busy !== 1'b0 || pkt_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: got pe=%b busy=%b done=%b required 0 0 0", pack_enable, busy, pkt_done);
        end
        rst = 1'b0;
        sn_model = '0;
        req_valid = 1'b1;
        req_len_m1 = 4'd1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (pkt_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_restart: got done=%b busy=%b required 0 1", pkt_done, busy);
        end
        w0 = $urandom;
        wr_valid = 1'b1;
        wr_data = w0;
        @(negedge clk);
        checks++;
        if ({pack_enable, flit_type, SN_out, payload} !== {1'b1, 2'b01, 5'd0, w0}) begin
            errors++;
            $display("[TB] FAIL mid_head: got pe=%b ty=%b sn=%0d pl=%h required 1 01 0 %h",
                     pack_enable, flit_type, SN_out, payload, w0);
        end
        w1 = $urandom;
        wr_data = w1;
        @(negedge clk);
        wr_valid = 1'b0;
        checks++;
        if ({pack_enable, flit_type, SN_out, payload} !== {1'b1, 2'b10, 5'd1, w1}) begin
            errors++;
            $display("[TB] FAIL mid_tail: got pe=%b ty=%b sn=%0d pl=%h required 1 10 1 %h",
                     pack_enable, flit_type, SN_out, payload, w1);
        end
        @(negedge clk);
        checks++;
        if (pkt_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_done: got %b required 1", pkt_done);
        end
    endtask

    initial begin
        rst = 1'b1;
        src_id = '0;
        req_valid = 1'b0;
        req_dest = '0;
        req_len_m1 = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        link_status = 1'b1;
        test_reset();
        test_single();
        test_four_flit();
        test_backpressure();
        test_back_to_back(25);
        test_sn_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnic_tx_packetizer.md
# cnic_tx_packetizer

Transmit-side packetizer in the CNIC, directly upstream of the flit packer. It accepts a packet request (destination, length) and a stream of payload words from the local core. For each flit it drives the packer's input bundle: payload, flit type, sequence number, destination, source and `pack_enable`. It stalls on the link status the packer reflects back.

## Interface
- `PAYLOAD_WIDTH`, 32, payload bits per flit
- `FLIT_TYPE_WIDTH`, 2, flit type field width
- `XY_WIDTH`, 2, bits per X or Y coordinate; node IDs are `2*XY_WIDTH` wide
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `src_id`  in  2*XY_WIDTH  this node's coordinates; static
- `req_valid`  in  1  packet request valid
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_dest`  in  2*XY_WIDTH  destination coordinates
- `req_len_m1`  in  4  number of flits minus 1 (0..15 gives 1..16 flits)
- `wr_valid`  in  1  payload word valid
- `wr_ready`  out  1  word accepted when `wr_valid && wr_ready`
- `wr_data`  in  PAYLOAD_WIDTH  payload word
- `payload`  out  PAYLOAD_WIDTH  flit payload to packer
- `flit_type`  out  FLIT_TYPE_WIDTH  00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE
- `pack_enable`  out  1  flit bundle valid
- `dest`  out  2*XY_WIDTH  destination of current packet
- `src`  out  2*XY_WIDTH  copy of `src_id` captured at request
- `SN_out`  out  5  per-flit sequence number
- `link_status`  in  1  from packer; 1 means the flit presented this cycle is consumed
- `busy`  out  1  state is not IDLE
- `pkt_done`  out  1  one-cycle pulse when the last flit of a packet is consumed

## Operation
- FSM states:
  - IDLE → SEND on request fire. Capture `req_dest`, `src_id` and `req_len_m1`; clear the flit index.
  - SEND → DRAIN on the fire of the word with index == len_m1.
  - DRAIN → IDLE on consumption of the last flit (`pack_enable && link_status`). Pulse `pkt_done` the following cycle.
- `req_ready` = (state == IDLE) combinationally. It is never high in SEND or DRAIN.
- Output register:
  - "Free" = `!pack_enable || link_status`.
  - `wr_ready` = (state == SEND) && free.
- On word fire:
  - Load `payload` = `wr_data`; set `pack_enable` = 1.
  - Set `dest` and `src` from the captured values.
  - Set `SN_out` = sn_cnt, then increment sn_cnt.
  - Increment the index.
- Flit type from index i and len_m1: SINGLE if len_m1 == 0; HEAD if i == 0; TAIL if i == len_m1; otherwise BODY.
- On consumption with no word fire in the same cycle: `pack_enable` → 0. All other fields hold their last value.
- Hold rule: while `pack_enable && !link_status`, every output field stays bit-stable.
- sn_cnt is a 5-bit counter spanning packets. It wraps 31 → 0 and only `rst` clears it.
- `wr_valid` outside SEND is ignored. The core must not present words before its request is accepted.
- Reset mid-operation aborts the packet:
  - State → IDLE, `pack_enable` → 0, sn_cnt → 0.
  - No `pkt_done`. Any partially sent packet is abandoned.

## Timing
- Reset values: `pack_enable` 0, `payload` 0, `flit_type` 00, `dest` 0, `src` 0, `SN_out` 0, `busy` 0, `pkt_done` 0.
- Combinational outputs during the reset cycle: `req_ready` 0, `wr_ready` 0. Handshakes in the reset cycle are ignored.
- Request fire at cycle T: `busy` = 1 and `wr_ready` can be high at T+1.
- Word fire at cycle T: the flit is visible on the outputs at T+1.
- Throughput is one flit per cycle when `link_status` stays 1. Consumption and the next load occur in the same cycle.
- Last flit consumed at cycle T: `pkt_done` = 1 at T+1, `busy` = 0 at T+1, `req_ready` = 1 at T+1.
- Minimum gap between packets is one cycle (the IDLE request cycle).

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all registered outputs 0. After release `req_ready` = 1, `busy` = 0.
- Single-flit packet, `link_status` = 1:
  - Stimulus: `src_id` 4'hA, `req_dest` 4'h5, `req_len_m1` 0, `wr_data` 32'hDEADBEEF.
  - Response: one cycle of `pack_enable` with type 11, `SN_out` 0, `dest` 5, `src` A; then `pkt_done` pulse; then `req_ready` = 1.
- Four-flit packet, link always 1, words 1..4 back-to-back → `pack_enable` high 4 consecutive cycles, types 01, 00, 00, 10, `SN_out` 0..3, one `pkt_done`.
- Backpressure: `link_status` = 0 for 3 cycles while flit 2 is presented → fields stable all 3 cycles, `wr_ready` 0, no SN advance. Resumes with flit 3 on the cycle after `link_status` returns to 1.
- SN wrap: 34 single-flit packets → `SN_out` runs 0..31, 0, 1; types all 11.
- Reset mid-packet after 2 of 4 flits consumed → next cycle `pack_enable` 0, `busy` 0, no `pkt_done`. A new 2-flit packet starts with type 01 and `SN_out` 0.
